pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// Module   : pc_sequencer_if
// Purpose  : Control/status bundle between an instruction decoder and pc_sequencer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if #(
   parameter int PCW = 12,
   parameter int B   = 3
);
   logic           i_start;
   logic           i_halt_req;
   logic           i_stall;
   logic           i_branch_en;
   logic           i_branch_cond;
   logic [B:0]     i_how_high;
   logic           i_jump_en;
   logic [PCW-1:0] i_jump_addr;
   logic [PCW-1:0] o_pc;
   logic           o_busy;
   logic           o_done;
   logic           o_taken;
   logic [15:0]    o_cycle_count;

   modport master (
      output i_start, i_halt_req, i_stall, i_branch_en, i_branch_cond,
             i_how_high, i_jump_en, i_jump_addr,
      input  o_pc, o_busy, o_done, o_taken, o_cycle_count
   );

   modport slave (
      input  i_start, i_halt_req, i_stall, i_branch_en, i_branch_cond,
             i_how_high, i_jump_en, i_jump_addr,
      output o_pc, o_busy, o_done, o_taken, o_cycle_count
   );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer with relative branches, jumps, stall and halt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pc_sequencer #(
   parameter int             PCW        = 12,
   parameter int             B          = 3,
   parameter logic [PCW-1:0] START_ADDR = '0
) (
   input  wire             clk,
   input  wire             rst_n,
   pc_sequencer_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [PCW-1:0] r_pc, w_pc_nxt;
   logic           r_taken, w_taken_nxt;
   logic [15:0]    r_cnt, w_cnt_nxt;
   logic signed [5:0] w_off6;
   logic [PCW-1:0] w_offset;

   // Odd indices are the negative twin of the preceding even index.
   always_comb begin
      w_off6 = '0;
      case (int'(bus.i_how_high))
         0:       w_off6 =  6'sd2;
         1:       w_off6 = -6'sd2;
         2:       w_off6 =  6'sd4;
         3:       w_off6 = -6'sd4;
         4:       w_off6 =  6'sd8;
         5:       w_off6 = -6'sd8;
         6:       w_off6 =  6'sd16;
         7:       w_off6 = -6'sd16;
         default: w_off6 = '0;
      endcase
      w_offset = PCW'(w_off6);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_taken_nxt = 1'b0;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_RUN: begin
            if (!bus.i_stall) begin
               w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
               if (bus.i_halt_req) begin
                  w_state_nxt = S_HALT;
               end else if (bus.i_jump_en) begin
                  w_pc_nxt    = bus.i_jump_addr;
                  w_taken_nxt = 1'b1;
               end else if (bus.i_branch_en && bus.i_branch_cond) begin
                  w_pc_nxt    = r_pc + w_offset;
                  w_taken_nxt = 1'b1;
               end else begin
                  w_pc_nxt = r_pc + {{(PCW-1){1'b0}}, 1'b1};
               end
            end
         end
         default: begin
            if (bus.i_start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = START_ADDR;
               w_cnt_nxt   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= START_ADDR;
         r_taken <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_taken <= w_taken_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign bus.o_pc          = r_pc;
   assign bus.o_taken       = r_taken;
   assign bus.o_cycle_count = r_cnt;
   assign bus.o_busy        = (r_state == S_RUN);
   assign bus.o_done        = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// Module   : tb_pc_sequencer
// Purpose  : Directed plus random checks of pc_sequencer against a behavioural model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   // Model: 0=idle, 1=run, 2=halt
   int m_state, m_pc, m_cnt, m_taken;

   pc_sequencer_if #(.PCW(12), .B(3)) ifc ();

   pc_sequencer #(.PCW(12), .B(3), .START_ADDR(12'd0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int offset_of(input int hh);
      if (hh >= 8) return 0;
      return ((hh % 2) ? -1 : 1) * (2 << (hh / 2));
   endfunction

   function automatic int wrap(input int v);
      return ((v % 4096) + 4096) % 4096;
   endfunction

   task automatic model_reset();
      m_state = 0; m_pc = 0; m_cnt = 0; m_taken = 0;
   endtask

   task automatic model_step();
      if (m_state != 1) begin
         m_taken = 0;
         if (ifc.i_start) begin m_state = 1; m_pc = 0; m_cnt = 0; end
      end else if (ifc.i_stall) begin
         m_taken = 0;
      end else begin
         if (m_cnt < 65535) m_cnt++;
         if (ifc.i_halt_req) begin
            m_state = 2; m_taken = 0;
         end else if (ifc.i_jump_en) begin
            m_pc = int'(ifc.i_jump_addr); m_taken = 1;
         end else if (ifc.i_branch_en && ifc.i_branch_cond) begin
            m_pc = wrap(m_pc + offset_of(int'(ifc.i_how_high))); m_taken = 1;
         end else begin
            m_pc = wrap(m_pc + 1); m_taken = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pc"},    32'(ifc.o_pc),          32'(m_pc));
      chk({tag, ".busy"},  32'(ifc.o_busy),        32'(m_state == 1));
      chk({tag, ".done"},  32'(ifc.o_done),        32'(m_state == 2));
      chk({tag, ".taken"}, 32'(ifc.o_taken),       32'(m_taken));
      chk({tag, ".cnt"},   32'(ifc.o_cycle_count), 32'(m_cnt));
   endtask

   task automatic drive(input bit st, input bit hr, input bit sl, input bit be,
                        input bit bc, input logic [3:0] hh, input bit je,
                        input logic [11:0] ja);
      ifc.i_start = st; ifc.i_halt_req = hr; ifc.i_stall = sl;
      ifc.i_branch_en = be; ifc.i_branch_cond = bc; ifc.i_how_high = hh;
      ifc.i_jump_en = je; ifc.i_jump_addr = ja;
   endtask

   task automatic tick(input string tag, input bit do_chk);
      @(posedge clk);
      model_step();
      #1;
      if (do_chk) check_all(tag);
   endtask

   initial begin
      int exp_br [8] = '{22, 18, 24, 16, 28, 12, 36, 4};
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk); rst_n = 1'b1;
      tick("idle_hold", 1);
      tick("idle_hold2", 1);

      // Sequential run
      drive(1, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("start", 1);
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      for (int i = 1; i <= 5; i++) begin
         tick("seq", 1);
         chk("seq.lit_pc", 32'(ifc.o_pc), 32'(i));
      end
      chk("seq.lit_cnt", 32'(ifc.o_cycle_count), 32'd5);

      // Start ignored in RUN
      drive(1, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("start_in_run", 1);

      // Branch sweep from pc=20
      for (int hh = 0; hh < 10; hh++) begin
         if (hh == 8) continue;
         drive(0, 0, 0, 0, 0, 4'd0, 1, 12'd20);
         tick("jump20", 1);
         drive(0, 0, 0, 1, 1, 4'(hh), 0, 12'd0);
         tick("branch", 1);
         if (hh < 8) chk("branch.lit_pc", 32'(ifc.o_pc), 32'(exp_br[hh]));
         else        chk("branch.hh9_pc", 32'(ifc.o_pc), 32'd20);
         chk("branch.lit_taken", 32'(ifc.o_taken), 32'd1);
      end
      drive(0, 0, 0, 0, 0, 4'd0, 1, 12'd20);
      tick("jump20", 1);
      drive(0, 0, 0, 1, 0, 4'd2, 0, 12'd0);
      tick("br_not_taken", 1);
      chk("br_not_taken.lit_pc", 32'(ifc.o_pc), 32'd21);
      chk("br_not_taken.lit_taken", 32'(ifc.o_taken), 32'd0);

      // Wrap below zero and jump-over-branch priority
      drive(0, 0, 0, 0, 0, 4'd0, 1, 12'd1);
      tick("jump1", 1);
      drive(0, 0, 0, 1, 1, 4'd1, 0, 12'd0);
      tick("wrap", 1);
      chk("wrap.lit_pc", 32'(ifc.o_pc), 32'd4095);
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("wrap_up", 1);
      chk("wrap_up.lit_pc", 32'(ifc.o_pc), 32'd0);
      drive(0, 0, 0, 0, 0, 4'd0, 1, 12'd10);
      tick("jump10", 1);
      drive(0, 0, 0, 1, 1, 4'd2, 1, 12'd300);
      tick("jump_prio", 1);
      chk("jump_prio.lit_pc", 32'(ifc.o_pc), 32'd300);

      // Stall wins over halt, halt follows once stall drops
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 1, 1, 4'd0, 1, 12'd7);
         tick("stall_halt", 1);
      end
      drive(0, 1, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("halt", 1);
      chk("halt.lit_done", 32'(ifc.o_done), 32'd1);
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("halt_hold", 1);
      drive(1, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("restart", 1);
      chk("restart.lit_pc", 32'(ifc.o_pc), 32'd0);

      // Asynchronous reset between edges at pc=57
      drive(0, 0, 0, 0, 0, 4'd0, 1, 12'd57);
      tick("jump57", 1);
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      @(negedge clk); rst_n = 1'b1;
      tick("post_rst", 1);
      tick("post_rst2", 1);

      // Random stimulus
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom),
               4'($urandom), ($urandom_range(0, 7) == 0), 12'($urandom));
         tick("rand", 1);
      end

      // Counter saturation
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      if (m_state == 1) begin
         drive(0, 1, 0, 0, 0, 4'd0, 0, 12'd0);
         tick("sat_halt", 1);
      end
      drive(1, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      tick("sat_start", 1);
      drive(0, 0, 0, 0, 0, 4'd0, 0, 12'd0);
      for (int i = 0; i < 65540; i++) tick("sat", 0);
      check_all("sat");
      chk("sat.lit_cnt", 32'(ifc.o_cycle_count), 32'd65535);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
